// File: rtl/axis_tx_frame_fifo.sv
// Store-and-forward AXI-stream frame FIFO in front of the MII TX MAC: only whole, error-free frames
// are released downstream. Define AXIS_TX_FIFO_STATS_EN to build the saturating drop_count counter.
module axis_tx_frame_fifo #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_data,
  input  logic        s_axis_valid,
  output logic        s_axis_ready,
  input  logic        s_axis_last,
  input  logic        s_axis_err,
  output logic [7:0]  m_axis_data,
  output logic        m_axis_valid,
  input  logic        m_axis_ready,
  output logic        m_axis_last,
  output logic        m_axis_err,
  output logic        frame_dropped,
  output logic [15:0] drop_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  localparam logic [0:0] ST_WRITE   = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

  logic [8:0]    mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [0:0]    state_q, state_d;
  logic          drop_q, drop_d;
  logic          active_q;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q;
  logic          out_last_q;

  logic full, have_data, oversize, s_hs, mem_we, load;

  assign full      = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
  assign have_data = commit_ptr_q != rd_ptr_q;
  // The frame in progress alone fills the RAM: it can never be committed.
  assign oversize  = full && !have_data;

  assign s_axis_ready = active_q && ((state_q == ST_DISCARD) || !full || oversize);
  assign s_hs         = s_axis_valid && s_axis_ready;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    state_d      = state_q;
    drop_d       = 1'b0;
    mem_we       = 1'b0;
    if (state_q == ST_DISCARD) begin
      if (s_hs && s_axis_last) state_d = ST_WRITE;
    end else if (oversize) begin
      wr_ptr_d = commit_ptr_q;
      drop_d   = 1'b1;
      if (!(s_axis_valid && s_axis_last)) state_d = ST_DISCARD;
    end else if (s_hs) begin
      if (s_axis_err) begin
        wr_ptr_d = commit_ptr_q;
        drop_d   = 1'b1;
        if (!s_axis_last) state_d = ST_DISCARD;
      end else begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (s_axis_last) commit_ptr_d = wr_ptr_q + PTR_ONE;
      end
    end
  end

  // The RAM read register doubles as the single-entry output stage.
  assign load        = have_data && (!out_valid_q || m_axis_ready);
  assign rd_ptr_d    = load ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  assign out_valid_d = load ? 1'b1 : (m_axis_ready ? 1'b0 : out_valid_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      state_q      <= ST_WRITE;
      drop_q       <= 1'b0;
      active_q     <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      state_q      <= state_d;
      drop_q       <= drop_d;
      active_q     <= 1'b1;
      out_valid_q  <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_data, s_axis_last};
    if (load) {out_data_q, out_last_q} <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  end

  assign m_axis_data   = out_data_q;
  assign m_axis_last   = out_last_q;
  assign m_axis_valid  = out_valid_q;
  assign m_axis_err    = 1'b0;
  assign frame_dropped = drop_q;

`ifdef AXIS_TX_FIFO_STATS_EN
  logic [15:0] drop_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_q <= '0;
    end else if (drop_d && (drop_count_q != 16'hffff)) begin
      drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign drop_count = drop_count_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_axis_tx_frame_fifo.sv
// Bench for axis_tx_frame_fifo (ADDR_WIDTH=6): queue-level reference model compared every cycle,
// plus directed frame scenarios with literal expectations.
module tb_axis_tx_frame_fifo;

  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
`ifdef AXIS_TX_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axis_data = '0;
  logic        s_axis_valid = 1'b0;
  logic        s_axis_ready;
  logic        s_axis_last = 1'b0;
  logic        s_axis_err = 1'b0;
  logic [7:0]  m_axis_data;
  logic        m_axis_valid;
  logic        m_axis_ready = 1'b0;
  logic        m_axis_last;
  logic        m_axis_err;
  logic        frame_dropped;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  axis_tx_frame_fifo #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .s_axis_last(s_axis_last), .s_axis_err(s_axis_err),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .m_axis_last(m_axis_last), .m_axis_err(m_axis_err),
    .frame_dropped(frame_dropped), .drop_count(drop_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: committed bytes waiting for the output stage, bytes of the open frame,
  // the byte held at the output, and the discard / dropped-frame bookkeeping.
  logic [8:0] cq[$];
  logic [8:0] pq[$];
  bit         mv = 1'b0;
  logic [8:0] mout = '0;
  bit         discard = 1'b0;
  bit         active = 1'b0;
  bit         mdrop = 1'b0;
  int         mcnt = 0;
  bit         cmp_en = 1'b0;

  function automatic bit model_ready();
    bit f;
    f = (cq.size() + pq.size()) == DEPTH;
    return active && (discard || !f || (f && cq.size() == 0));
  endfunction

  always @(posedge clk) begin : model
    bit full_pre, over_pre, rdy_pre;
    full_pre = (cq.size() + pq.size()) == DEPTH;
    over_pre = full_pre && (cq.size() == 0);
    rdy_pre  = model_ready();
    if (rst) begin
      cq.delete(); pq.delete();
      mv = 1'b0; discard = 1'b0; active = 1'b0; mdrop = 1'b0; mcnt = 0;
    end else begin
      active = 1'b1;
      mdrop  = 1'b0;
      if ((!mv || m_axis_ready) && cq.size() > 0) begin
        mout = cq.pop_front();
        mv   = 1'b1;
      end else if (m_axis_ready) begin
        mv = 1'b0;
      end
      if (discard) begin
        if (s_axis_valid && s_axis_last) discard = 1'b0;
      end else if (over_pre) begin
        pq.delete();
        mdrop = 1'b1;
        if (!(s_axis_valid && s_axis_last)) discard = 1'b1;
      end else if (rdy_pre && s_axis_valid) begin
        if (s_axis_err) begin
          pq.delete();
          mdrop = 1'b1;
          if (!s_axis_last) discard = 1'b1;
        end else begin
          pq.push_back({s_axis_data, s_axis_last});
          if (s_axis_last) begin
            foreach (pq[i]) cq.push_back(pq[i]);
            pq.delete();
          end
        end
      end
      if (mdrop && STATS && mcnt != 32'hffff) mcnt++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("s_ready", s_axis_ready, model_ready());
      check("m_valid", m_axis_valid, mv);
      if (mv) begin
        check("m_data", m_axis_data, mout[8:1]);
        check("m_last", m_axis_last, mout[0]);
      end
      check("m_err", m_axis_err, 1'b0);
      check("frame_dropped", frame_dropped, mdrop);
      check("drop_count", drop_count, mcnt[15:0]);
    end
  end

  logic [8:0] rx[$];
  int drops = 0;
  int beats_acc = 0;

  always @(posedge clk) begin
    if (!rst && m_axis_valid && m_axis_ready) rx.push_back({m_axis_data, m_axis_last});
    if (!rst && frame_dropped) drops++;
  end

  bit tog = 1'b0;
  initial forever begin
    @(negedge clk);
    if (tog) m_axis_ready = !m_axis_ready;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic send_beat(input logic [7:0] d, input logic l, input logic e);
    int n;
    n = 0;
    @(negedge clk);
    s_axis_data = d; s_axis_last = l; s_axis_err = e; s_axis_valid = 1'b1;
    while (!s_axis_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout actual=ready_low required=handshake");
    end
    @(posedge clk);
    beats_acc++;
  endtask

  function automatic logic [7:0] pat(input int f, input int i);
    return 8'((f * 37 + i) & 255);
  endfunction

  task automatic send_frame(input int f, input int len, input int err_at, input bit hold);
    for (int i = 0; i < len; i++) send_beat(pat(f, i), i == len - 1, i == err_at);
    if (!hold) begin
      @(negedge clk);
      s_axis_valid = 1'b0; s_axis_last = 1'b0; s_axis_err = 1'b0;
    end
  endtask

  task automatic expect_frame(input int f, input int len, input int base);
    int bad;
    bad = 0;
    if (rx.size() < base + len) bad = len;
    else for (int i = 0; i < len; i++)
      if (rx[base + i] !== {pat(f, i), i == len - 1}) bad++;
    check($sformatf("frame%0d_bytes", f), bad, 0);
  endtask

  function automatic int count_lasts();
    int c;
    c = 0;
    foreach (rx[i]) if (rx[i][0]) c++;
    return c;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [8:0] b;
    wait_cycles(2);
    cmp_en = 1'b1;
    check("rst_s_ready", s_axis_ready, 1'b0);
    check("rst_m_valid", m_axis_valid, 1'b0);
    check("rst_dropped", frame_dropped, 1'b0);
    check("rst_drop_count", drop_count, 16'h0);
    rst = 1'b0;
    wait_cycles(1);
    check("post_rst_ready", s_axis_ready, 1'b1);

    // 60-byte good frame, MAC always ready
    m_axis_ready = 1'b1;
    rx.delete();
    send_frame(1, 60, -1, 1'b0);
    check("t1_latency_edge1", m_axis_valid, 1'b0);
    wait_cycles(1);
    check("t1_latency_edge2", m_axis_valid, 1'b1);
    wait_cycles(70);
    check("t1_len", rx.size(), 60);
    b = rx[0];
    check("t1_first", b[8:1], 8'h25);
    b = rx[59];
    check("t1_lastbyte", b, {8'h60, 1'b1});
    check("t1_lasts", count_lasts(), 1);
    expect_frame(1, 60, 0);

    // error on byte 50 of a 100-byte frame, then a good 64-byte frame
    rx.delete(); drops = 0;
    send_frame(2, 100, 49, 1'b0);
    send_frame(3, 64, -1, 1'b0);
    wait_cycles(80);
    check("t2_drops", drops, 1);
    check("t2_len", rx.size(), 64);
    b = rx[0];
    check("t2_first", b[8:1], 8'h6f);
    expect_frame(3, 64, 0);
    check("t2_drop_count", drop_count, STATS ? 16'd1 : 16'd0);

    // oversize 80-byte frame with the MAC stalled, then a 20-byte frame
    m_axis_ready = 1'b0;
    rx.delete(); drops = 0; beats_acc = 0;
    send_frame(4, 80, -1, 1'b0);
    wait_cycles(5);
    check("t3_drops", drops, 1);
    check("t3_accepted", beats_acc, 80);
    check("t3_no_output", m_axis_valid, 1'b0);
    m_axis_ready = 1'b1;
    send_frame(5, 20, -1, 1'b0);
    wait_cycles(30);
    check("t3_len", rx.size(), 20);
    expect_frame(5, 20, 0);
    check("t3_drop_count", drop_count, STATS ? 16'd2 : 16'd0);

    // committed frame plus a second frame that stalls on full until the MAC drains
    m_axis_ready = 1'b0;
    rx.delete(); beats_acc = 0;
    send_frame(6, 40, -1, 1'b0);
    wait_cycles(3);
    fork
      send_frame(7, 40, -1, 1'b0);
      begin
        wait_cycles(60);
        check("t4_stall_ready", s_axis_ready, 1'b0);
        check("t4_accepted", beats_acc, 65);
        m_axis_ready = 1'b1;
      end
    join
    wait_cycles(100);
    check("t4_len", rx.size(), 80);
    expect_frame(6, 40, 0);
    expect_frame(7, 40, 40);

    // three back-to-back 64-byte frames with MAC ready toggling
    rx.delete();
    tog = 1'b1;
    send_frame(8, 64, -1, 1'b1);
    send_frame(9, 64, -1, 1'b1);
    send_frame(10, 64, -1, 1'b0);
    wait_cycles(400);
    tog = 1'b0;
    m_axis_ready = 1'b1;
    wait_cycles(10);
    check("t5_len", rx.size(), 192);
    check("t5_lasts", count_lasts(), 3);
    b = rx[128];
    check("t5_f10_first", b[8:1], 8'h72);
    expect_frame(8, 64, 0);
    expect_frame(9, 64, 64);
    expect_frame(10, 64, 128);

    // reset while a frame is being read and another is being written
    rx.delete();
    m_axis_ready = 1'b0;
    send_frame(11, 30, -1, 1'b0);
    m_axis_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_beat(pat(12, i), 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    s_axis_valid = 1'b0;
    wait_cycles(1);
    check("t6_rst_m_valid", m_axis_valid, 1'b0);
    check("t6_rst_s_ready", s_axis_ready, 1'b0);
    check("t6_partial_read", (rx.size() > 0) && (rx.size() < 30), 1'b1);
    rst = 1'b0;
    rx.delete();
    wait_cycles(2);
    send_frame(13, 64, -1, 1'b0);
    wait_cycles(80);
    check("t6_len", rx.size(), 64);
    expect_frame(13, 64, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
